// File: rtl/store_narrow_buffer.sv
// store_narrow_buffer: narrows 32-bit store data into little-endian byte lanes with byte
// enables, queues word-aligned writes in a FIFO and drains them over a valid/ready port.
// Misaligned stores and the reserved size are consumed without enqueueing and raise a
// one-cycle addr_err pulse.
// Optional feature: define STORE_MERGE_EN to merge a store into the youngest entry when it
// targets the same word.
module store_narrow_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_addr,
    input  logic [31:0]      in_data,
    input  logic [1:0]       in_size,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    output logic             addr_err,
    output logic [31:0]      err_addr,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entry storage; only the word address is kept since bits [1:0] are always zero.
    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       be_q   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             addr_err_q;
    logic [31:0]      err_addr_q;

    logic [1:0]       ofs;
    logic             legal;
    logic [31:0]      n_wdata;
    logic [3:0]       n_be;

    logic             full, empty;
    logic             accept, push, pop, merge;

    assign ofs = in_addr[1:0];

    // Decode size/offset into lane-replicated data, byte enables and legality.
    always_comb begin
        legal   = 1'b0;
        n_wdata = '0;
        n_be    = '0;
        case (in_size)
            2'b00: begin
                legal   = 1'b1;
                n_wdata = {4{in_data[7:0]}};
                n_be    = 4'b0001 << ofs;
            end
            2'b01: begin
                legal   = ~ofs[0];
                n_wdata = {2{in_data[15:0]}};
                n_be    = ofs[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                legal   = (ofs == 2'b00);
                n_wdata = in_data;
                n_be    = 4'b1111;
            end
            default: begin
                legal   = 1'b0;
            end
        endcase
    end

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign pop   = !empty && mem_ready;

`ifdef STORE_MERGE_EN
    logic [PTR_W-1:0] tail_ptr;
    logic [31:0]      merged_data;

    assign tail_ptr = wr_ptr_q - PTR_W'(1);

    // Merge into the youngest entry unless it is the sole entry leaving this cycle.
    always_comb begin
        merge = in_valid && legal && !empty && (addr_q[tail_ptr] == in_addr[31:2])
                && !(pop && (count_q == CNT_W'(1)));
        merged_data = data_q[tail_ptr];
        for (int i = 0; i < 4; i++) begin
            if (n_be[i]) begin
                merged_data[8*i +: 8] = n_wdata[8*i +: 8];
            end
        end
    end
`else
    assign merge = 1'b0;
`endif

    // No full-cycle bypass: a pop does not free a slot for the same edge.
    assign in_ready = !full || merge;
    assign accept   = in_valid && in_ready;
    assign push     = accept && legal && !merge;

    // Occupancy next state.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, occupancy and error reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            addr_err_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            count_q    <= count_d;
            addr_err_q <= accept && !legal;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (accept && !legal) begin
                err_addr_q <= in_addr;
            end
        end
    end

    // Entry payload writes; contents are don't-care until allocated, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            addr_q[wr_ptr_q] <= in_addr[31:2];
            data_q[wr_ptr_q] <= n_wdata;
            be_q[wr_ptr_q]   <= n_be;
        end
`ifdef STORE_MERGE_EN
        else if (!rst && merge) begin
            data_q[tail_ptr] <= merged_data;
            be_q[tail_ptr]   <= be_q[tail_ptr] | n_be;
        end
`endif
    end

    // Head presentation; outputs read zero while empty.
    always_comb begin
        mem_valid = !empty;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (!empty) begin
            mem_addr  = {addr_q[rd_ptr_q], 2'b00};
            mem_wdata = data_q[rd_ptr_q];
            mem_be    = be_q[rd_ptr_q];
        end
    end

    assign addr_err = addr_err_q;
    assign err_addr = err_addr_q;
    assign count    = count_q;

endmodule

// File: tb/tb_store_narrow_buffer.sv
// tb_store_narrow_buffer: directed plus randomized stimulus against a queue-based
// reference model of the store narrowing buffer.
module tb_store_narrow_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;
`ifdef STORE_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_addr;
    logic [31:0]      in_data;
    logic [1:0]       in_size;
    logic             mem_valid;
    logic             mem_ready;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_be;
    logic             addr_err;
    logic [31:0]      err_addr;
    logic [CNT_W-1:0] count;

    store_narrow_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_size   (in_size),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .addr_err  (addr_err),
        .err_addr  (err_addr),
        .count     (count)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    ent_t        q[$];
    logic        m_err;
    logic [31:0] m_err_addr;

    // Per-cycle derived model values for the currently driven inputs.
    logic        m_legal, m_pop, m_merge, m_ready;
    logic [31:0] m_wd;
    logic [3:0]  m_be;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        int o;
        o = int'(in_addr % 4);
        m_legal = 1'b0;
        m_wd    = '0;
        m_be    = '0;
        if (in_size == 2'd0) begin
            m_legal = 1'b1;
            m_wd    = {4{in_data[7:0]}};
            m_be    = 4'(1 << o);
        end else if (in_size == 2'd1) begin
            m_legal = (o % 2 == 0);
            m_wd    = {2{in_data[15:0]}};
            m_be    = 4'(3 << o);
        end else if (in_size == 2'd2) begin
            m_legal = (o == 0);
            m_wd    = in_data;
            m_be    = 4'hf;
        end
        m_pop   = (q.size() != 0) && mem_ready;
        m_merge = MERGE && in_valid && m_legal && (q.size() != 0)
                  && (q[q.size()-1].addr == (in_addr & 32'hffff_fffc))
                  && !(m_pop && q.size() == 1);
        m_ready = (q.size() != DEPTH) || m_merge;
    endtask

    task automatic check_state();
        ent_t h;
        model_eval();
        check("in_ready", in_ready, m_ready);
        check("mem_valid", mem_valid, q.size() != 0);
        if (q.size() != 0) h = q[0];
        else begin
            h.addr = 0; h.data = 0; h.be = 0;
        end
        check("mem_addr", mem_addr, h.addr);
        check("mem_wdata", mem_wdata, h.data);
        check("mem_be", mem_be, h.be);
        check("count", count, q.size());
        check("count_bound", count <= DEPTH, 1);
        check("addr_err", addr_err, m_err);
        check("err_addr", err_addr, m_err_addr);
    endtask

    task automatic model_step();
        ent_t e;
        logic acc;
        if (rst) begin
            q.delete();
            m_err      = 1'b0;
            m_err_addr = '0;
            return;
        end
        acc   = in_valid && m_ready;
        m_err = acc && !m_legal;
        if (m_err) m_err_addr = in_addr;
        if (acc && m_legal && m_merge) begin
            e = q.pop_back();
            for (int i = 0; i < 4; i++)
                if (m_be[i]) e.data[8*i +: 8] = m_wd[8*i +: 8];
            e.be = e.be | m_be;
            q.push_back(e);
        end
        if (m_pop) void'(q.pop_front());
        if (acc && m_legal && !m_merge) begin
            e.addr = in_addr & 32'hffff_fffc;
            e.data = m_wd;
            e.be   = m_be;
            q.push_back(e);
        end
    endtask

    // One clock: settle, compare, advance model, cross the edge, return at negedge.
    task automatic tick();
        #1;
        check_state();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        in_size  = s;
    endtask

    initial begin
        rst = 1'b1;
        mem_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'd0);
        @(posedge clk);
        @(negedge clk);
        q.delete();
        m_err = 1'b0;
        m_err_addr = '0;
        tick();
        rst = 1'b0;
        #1;
        check("reset_count", count, 0);
        check("reset_mem_valid", mem_valid, 0);
        check("reset_addr_err", addr_err, 0);

        // Word store straight through.
        mem_ready = 1'b1;
        drive(1'b1, 32'h100, 32'hDEADBEEF, 2'd2);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'd0);
        #1;
        check("sw_valid", mem_valid, 1);
        check("sw_addr", mem_addr, 32'h100);
        check("sw_wdata", mem_wdata, 32'hDEADBEEF);
        check("sw_be", mem_be, 4'b1111);
        tick();
        check("sw_drained", count, 0);

        // Byte and halfword lane placement.
        drive(1'b1, 32'h203, 32'h000000A5, 2'd0);
        tick();
        drive(1'b1, 32'h206, 32'h00001234, 2'd1);
        #1;
        check("sb_addr", mem_addr, 32'h200);
        check("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        check("sb_be", mem_be, 4'b1000);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'd0);
        #1;
        check("sh_addr", mem_addr, 32'h204);
        check("sh_wdata", mem_wdata, 32'h12341234);
        check("sh_be", mem_be, 4'b1100);
        tick();

        // Back-to-back misaligned stores.
        drive(1'b1, 32'h101, 32'h0, 2'd2);
        tick();
        drive(1'b1, 32'h303, 32'h0, 2'd1);
        #1;
        check("err1_pulse", addr_err, 1);
        check("err1_addr", err_addr, 32'h101);
        check("err1_count", count, 0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'd0);
        #1;
        check("err2_pulse", addr_err, 1);
        check("err2_addr", err_addr, 32'h303);
        check("err2_valid", mem_valid, 0);
        tick();
        check("err_clear", addr_err, 0);

        // Fill, stall, then drain in order.
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 32'h1000 + 32'(i), 2'd2);
            tick();
        end
        #1;
        check("full_count", count, 4);
        check("full_ready", in_ready, 0);
        tick();
        check("stall_head", mem_addr, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 2'd0);
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_order", mem_addr, 32'(4 * i));
            tick();
        end
        check("drain_empty", count, 0);

        // Full with simultaneous push and pop, then reset with entries queued.
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h40 + 32'(4 * i), 32'h0, 2'd2);
            tick();
        end
        drive(1'b1, 32'h80, 32'h55, 2'd2);
        mem_ready = 1'b1;
        #1;
        check("full_pushpop_ready", in_ready, 0);
        tick();
        check("full_pushpop_count", count, 3);
        drive(1'b0, 32'h0, 32'h0, 2'd0);
        mem_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_count", count, 0);
        check("rst_mid_valid", mem_valid, 0);

        // Adjacent bytes to the same word.
        drive(1'b1, 32'h400, 32'h11, 2'd0);
        tick();
        drive(1'b1, 32'h401, 32'h22, 2'd0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'd0);
        #1;
        check("merge_count", count, MERGE ? 1 : 2);
        check("merge_be", mem_be, MERGE ? 4'b0011 : 4'b0001);
        check("merge_lo", mem_wdata[15:0], MERGE ? 16'h2211 : 16'h1111);
        mem_ready = 1'b1;
        tick();
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 63) == 0);
            mem_ready = ($urandom_range(0, 9) < 4);
            drive($urandom_range(0, 3) != 0,
                  32'h500 + 32'($urandom_range(0, 3) << 2) + 32'($urandom_range(0, 3)),
                  $urandom, 2'($urandom_range(0, 3)));
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'd0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
